// File: rtl/sp_pkg.sv
// Shared types for the series-processor result buffer: data word, FIFO entry, burst FSM state.
// No logic of its own; the buffer has 2-cycle fill latency and ready/valid output flow control.
// Build option SP_RB_CG_EN (clock-gated storage/accumulator) is selected in the modules, not here.
package sp_pkg;

  localparam int SP_DEPTH     = 8;
  localparam int SP_MAX_BURST = 16;
  // Sum width covers MAX_BURST full-scale 9-bit words: 9 + log2(16).
  localparam int SP_SUM_W     = 13;

  typedef logic signed [8:0]          sp_word_t;
  typedef logic signed [SP_SUM_W-1:0] sp_sum_t;

  // One FIFO slot; sum is only non-zero on the last word of a burst.
  typedef struct packed {
    logic     last;
    sp_word_t data;
    sp_sum_t  sum;
  } rb_entry_t;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } rb_state_t;

endpackage

// File: rtl/sp_rb_fifo.sv
// Result FIFO: registered storage array with wrap pointers (extra MSB separates full from empty).
// Latency: a push is visible at the head on the next cycle; push and pop both allowed every cycle.
// Backpressure: a push while full is refused unless a pop happens in the same cycle. SP_RB_CG_EN adds clock gating.
module sp_rb_fifo
  import sp_pkg::*;
#(
  parameter int DEPTH = SP_DEPTH
)(
  input  logic      clk,
  input  logic      rst,
`ifdef SP_RB_CG_EN
  input  logic      cg_en,
  input  logic      acc_en,
  output logic      acc_clk,
`endif
  input  logic      push,
  input  rb_entry_t wdata,
  input  logic      pop,
  output rb_entry_t head,
  output logic      empty,
  output logic      full
);

  localparam int PW = $clog2(DEPTH);

  rb_entry_t     mem [DEPTH];
  logic [PW:0]   wr_ptr;
  logic [PW:0]   rd_ptr;
  logic          st_clk;
  logic          push_ok;
  logic          pop_ok;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign head    = mem[rd_ptr[PW-1:0]];

`ifdef SP_RB_CG_EN
  logic st_en_l;
  logic acc_en_l;

  // Clock-gating cell: enables are latched while clk is low so the gated clocks never glitch.
  always_latch begin
    if (!clk) begin
      st_en_l  = push | ~cg_en;
      acc_en_l = acc_en | ~cg_en;
    end
  end

  assign st_clk  = clk & st_en_l;
  assign acc_clk = clk & acc_en_l;
`else
  assign st_clk = clk;
`endif

  // Storage write; contents need no reset because the pointers define validity.
  always_ff @(posedge st_clk) begin
    if (push_ok) begin
      mem[wr_ptr[PW-1:0]] <= wdata;
    end
  end

  // Pointer update; both may advance in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/sp_result_buffer.sv
// Captures SP output bursts, tags the last word of each burst with its signed sum, re-emits on ready/valid.
// Latency: sp_valid in cycle N appears at dout in cycle N+2 when the FIFO is empty.
// Backpressure: consumer stalls fill the FIFO; a word arriving while full is dropped and overflow latches. SP_RB_CG_EN adds cg_en.
module sp_result_buffer
  import sp_pkg::*;
#(
  parameter int DEPTH     = SP_DEPTH,
  parameter int MAX_BURST = SP_MAX_BURST,
  // Must equal SP_SUM_W, which sizes the stored sum field.
  parameter int SUM_W     = SP_SUM_W
)(
  input  logic             clk,
  input  logic             rst,
`ifdef SP_RB_CG_EN
  input  logic             cg_en,
`endif
  input  logic             sp_valid,
  input  logic [8:0]       sp_data,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic [8:0]       dout_data,
  output logic             dout_last,
  output logic [SUM_W-1:0] dout_sum,
  output logic             overflow
);

  localparam int CW = $clog2(MAX_BURST);

  logic                    stg_v;
  sp_word_t                stg_d;
  rb_state_t               state;
  logic [CW-1:0]           cnt;
  logic signed [SUM_W-1:0] acc;
  logic signed [SUM_W-1:0] sum_next;
  logic                    commit;
  logic                    last_w;
  logic                    pop;
  logic                    fifo_push;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    acc_clk;
  rb_entry_t               wr_entry;
  rb_entry_t               head;

  // A staged word ends its burst if no word follows it or the burst has hit its length cap.
  assign commit    = stg_v;
  assign last_w    = ~sp_valid | (cnt == CW'(MAX_BURST - 1));
  assign sum_next  = acc + {{(SUM_W-9){stg_d[8]}}, stg_d};
  assign pop       = dout_valid & dout_ready;
  assign fifo_push = commit & (~fifo_full | pop);

  // Build the FIFO entry for the staged word; sum rides only on the last word.
  always_comb begin
    wr_entry      = '0;
    wr_entry.last = last_w;
    wr_entry.data = stg_d;
    wr_entry.sum  = last_w ? sum_next : '0;
  end

  // Stage register decouples input capture from the last-word decision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg_v <= 1'b0;
      stg_d <= '0;
    end else begin
      stg_v <= sp_valid;
      stg_d <= sp_data;
    end
  end

  // Burst FSM: a single-word burst never leaves IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (commit && !last_w) state <= BURST;
        BURST:   if (commit && last_w)  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Word counter within the burst; restarts after each last word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (commit) begin
      cnt <= last_w ? '0 : cnt + 1'b1;
    end
  end

  // Running burst sum; keeps counting dropped words so the tagged sum stays complete.
  always_ff @(posedge acc_clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (stg_v) begin
      acc <= last_w ? '0 : sum_next;
    end
  end

  // Sticky drop flag: a commit into a full FIFO with no pop loses the word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (commit && fifo_full && !pop) begin
      overflow <= 1'b1;
    end
  end

`ifndef SP_RB_CG_EN
  assign acc_clk = clk;
`endif

  sp_rb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
`ifdef SP_RB_CG_EN
    .cg_en   (cg_en),
    .acc_en  (stg_v),
    .acc_clk (acc_clk),
`endif
    .push    (fifo_push),
    .wdata   (wr_entry),
    .pop     (pop),
    .head    (head),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  // Head fields are forced to zero when nothing is stored so idle outputs are clean.
  assign dout_valid = ~fifo_empty;
  assign dout_data  = dout_valid ? head.data : '0;
  assign dout_last  = dout_valid ? head.last : 1'b0;
  assign dout_sum   = dout_valid ? head.sum  : '0;

endmodule

// File: doc/sp_result_buffer.md
# sp_result_buffer

Downstream stage of the series processor. Captures each output burst (`out_valid`/`out_data`, 9-bit signed, no back-pressure) into a small FIFO and tags the final word of each burst. Computes a running signed sum per burst. Re-emits the words on a ready/valid stream to the consumer (pattern checker or next processing stage). Absorbs consumer stalls; overflow is reported, never silently ignored.

## Interface
Parameters:
- `DEPTH`, 8 — FIFO entries; power of two, ≥2.
- `MAX_BURST`, 16 — maximum words per burst before a forced burst end; power of two.
- `SUM_W`, 13 — burst-sum width; equals 9 + log2(MAX_BURST).

Ports:
- `clk`  in  1  — single clock; all state on rising edge.
- `rst`  in  1  — asynchronous, active-high reset.
- `sp_valid`  in  1  — SP `out_valid`; high for each burst word, bursts are contiguous.
- `sp_data`  in  9  — SP `out_data`, two's-complement signed.
- `dout_valid`  out  1  — FIFO head valid.
- `dout_ready`  in  1  — consumer accepts head when high with `dout_valid`.
- `dout_data`  out  9  — head word.
- `dout_last`  out  1  — head is the final word of its burst.
- `dout_sum`  out  SUM_W  — signed sum of the burst; meaningful only when `dout_last`=1, else 0.
- `overflow`  out  1  — sticky; set when a word is dropped.
- `cg_en`  in  1  — present only with `SP_RB_CG_EN` (see Configuration).

## Operation
- Stage register: `sp_valid`/`sp_data` captured each edge into `stg_v`/`stg_d`. The word in the stage is committed on the next edge with `last = ~sp_valid | (cnt == MAX_BURST-1)`.
- Burst FSM, states IDLE and BURST:
  - IDLE→BURST on a committed non-last word.
  - BURST→IDLE on a committed last word.
  - A committed last word in IDLE (1-word burst) stays in IDLE.
- `cnt` counts committed words in the current burst; it clears on commit of a last word.
- Accumulator: `acc` is sign-extended to SUM_W. The stored sum is `acc + stg_d` on commit of a last word. `acc` clears on last, otherwise accumulates.
- Forced end: the 16th consecutive word is tagged last. A word following it starts a new burst at `cnt`=0.
- FIFO entry = {last, data, sum}; `sum` field is 0 for non-last entries.
- Commit while full and `dout_ready & dout_valid` low: word dropped and `overflow` set.
  - Burst counting and accumulation still advance, so the tagged sum covers all words including dropped ones.
- Commit while full with a simultaneous pop: write succeeds.
- Pop on an empty FIFO is ignored. Pointers wrap modulo DEPTH; the extra pointer MSB distinguishes full from empty.

## Timing
- Reset values: `dout_valid`=0, `dout_data`=0, `dout_last`=0, `dout_sum`=0, `overflow`=0, FSM=IDLE, `cnt`=0, `acc`=0, stage empty.
- Latency: word present with `sp_valid` in cycle N → visible at head in cycle N+2 if the FIFO is empty.
- Head outputs are driven from registered FIFO storage; there is no combinational path from `sp_*` to `dout_*`.
- Head holds stable while `dout_valid & ~dout_ready`.
- Reset mid-burst discards all stored words, the partial sum and the overflow flag. Outputs return to reset values asynchronously.
- Throughput: one push and one pop per cycle, sustained.

## Configuration
- `SP_RB_CG_EN` defined: adds the `cg_en` port.
  - When `cg_en`=1, FIFO storage and accumulator update only through an enable-gated clock, using an integrated clock-gating cell instantiated in the sub-module.
  - The gate opens on commit (storage) or `stg_v` (accumulator).
  - When `cg_en`=0, the clock is ungated.
- Undefined: no `cg_en` port; all registers are clocked directly and use plain enables. Functional behaviour is identical in both builds.

## Structure
- Shared package `sp_pkg`: `sp_word_t` (signed [8:0]), `rb_entry_t` struct {last, data, sum}, FSM state enum {IDLE, BURST}, default DEPTH / MAX_BURST constants.
- One sub-module: `sp_rb_fifo` — storage array plus pointers, with the optional clock-gating cell.
- Top module holds the stage register, FSM, counter, accumulator and overflow flag.

## Test plan
- 3-word burst 5, −2, 100 with `dout_ready`=1 → three outputs starting 2 cycles after the first input. Last word 100 carries `dout_last`=1, `dout_sum`=103; the others carry sum 0.
- 1-word burst −256 → single output with `dout_last`=1 and `dout_sum`=−256; FSM stays IDLE.
- 20-word continuous burst of value 255 → word 16 tagged last with sum 4080. The remaining 4 words form a second burst, last sum 1020.
- `dout_ready`=0, 10-word burst of value 1 → 8 words stored, 2 dropped, `overflow`=1. After the stall, 8 words drain with no last tag; the last word was dropped.
- Full FIFO, simultaneous push and pop every cycle → no drop and `overflow` stays 0.
- `rst` pulsed mid-burst → `dout_valid`=0 immediately. The next burst 7, 8 yields sum 15, with no stale accumulator value.
